// File: rtl/spi_seq_pkg.sv
// Shared types and constants for the ADC-to-DAC SPI pass-through sequencer.
package spi_seq_pkg;
    typedef enum logic [2:0] {IDLE, START, SHIFT, DONE, GAP} seq_state_e;

    localparam int         FRAME_BITS_C    = 16;
    localparam int         DATA_BITS_C     = 12;
    localparam logic [3:0] DAC_CTRL_NORMAL = 4'b0000;
endpackage

// File: rtl/sclk_tick_gen.sv
// SCLK divider: toggles sclk every CLK_DIV clocks while run is high, parks it low otherwise.
// rise_tick/fall_tick are high in the clock whose closing edge moves sclk.
module sclk_tick_gen
    import spi_seq_pkg::*;
#(
    parameter int CLK_DIV = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic run,
    output logic sclk,
    output logic rise_tick,
    output logic fall_tick
);
    localparam int            CW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          sclk_q, sclk_d;
    logic          wrap;

    always_comb begin
        wrap   = run && (cnt_q == LAST);
        cnt_d  = '0;
        sclk_d = 1'b0;
        if (run) begin
            cnt_d  = wrap ? '0 : cnt_q + 1'b1;
            sclk_d = wrap ? ~sclk_q : sclk_q;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q  <= '0;
            sclk_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            sclk_q <= sclk_d;
        end
    end

    assign sclk      = sclk_q;
    assign rise_tick = wrap && !sclk_q;
    assign fall_tick = wrap && sclk_q;
endmodule

// File: rtl/spi_passthru_sequencer.sv
// Frame sequencer: one ADC word in and one DAC word out per 16-bit SPI frame on a shared SCLK.
// Define SEQ_RAMP_EN to replace the DAC data with an incrementing ramp (ADC capture unchanged).
module spi_passthru_sequencer
    import spi_seq_pkg::*;
#(
    parameter int CLK_DIV    = 2,
    parameter int FRAME_BITS = FRAME_BITS_C,
    parameter int DATA_BITS  = DATA_BITS_C,
    parameter int GAP_CYCLES = 2
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 adc_sdata,
    output logic                 sclk,
    output logic                 adc_cs_n,
    output logic                 dac_sync_n,
    output logic                 dac_sdata,
    output logic [DATA_BITS-1:0] sample,
    output logic                 sample_valid,
    output logic                 busy
);
    localparam int BW = $clog2(FRAME_BITS + 1);
    localparam int GW = $clog2(GAP_CYCLES + 1);

    seq_state_e            state_q, state_d;
    logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
    logic [GW-1:0]         gap_cnt_q, gap_cnt_d;
    logic [DATA_BITS-1:0]  rx_q, rx_d, rx_shift;
    logic [FRAME_BITS-1:0] tx_q, tx_d;
    logic [FRAME_BITS-1:0] dac_word_q, dac_word_d;
    logic                  cs_n_q, cs_n_d;
    logic                  sync_n_q, sync_n_d;
    logic                  sdata_q, sdata_d;
    logic [DATA_BITS-1:0]  sample_q, sample_d;
    logic                  valid_q, valid_d;
    logic [DATA_BITS-1:0]  dac_data;
    logic                  rise_tick, fall_tick;

    sclk_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
        .clock     (clock),
        .reset     (reset),
        .run       (state_q != IDLE),
        .sclk      (sclk),
        .rise_tick (rise_tick),
        .fall_tick (fall_tick)
    );

    // Only the low DATA_BITS of the frame survive, so older bits simply fall off the top.
    assign rx_shift = DATA_BITS'({rx_q, adc_sdata});

`ifdef SEQ_RAMP_EN
    logic [DATA_BITS-1:0] ramp_q, ramp_d;
    assign dac_data = ramp_q + 1'b1;
`else
    assign dac_data = rx_shift;
`endif

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        rx_d       = rx_q;
        tx_d       = tx_q;
        dac_word_d = dac_word_q;
        cs_n_d     = cs_n_q;
        sync_n_d   = sync_n_q;
        sdata_d    = sdata_q;
        sample_d   = sample_q;
        valid_d    = 1'b0;
`ifdef SEQ_RAMP_EN
        ramp_d     = ramp_q;
`endif
        case (state_q)
            IDLE: if (enable) state_d = START;
            START: begin
                if (fall_tick) begin
                    cs_n_d    = 1'b0;
                    sync_n_d  = 1'b0;
                    tx_d      = dac_word_q;
                    sdata_d   = dac_word_q[FRAME_BITS-1];
                    bit_cnt_d = '0;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                if (rise_tick && bit_cnt_q < BW'(FRAME_BITS)) sdata_d = tx_q[FRAME_BITS-1];
                if (fall_tick) begin
                    rx_d      = rx_shift;
                    tx_d      = tx_q << 1;
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    // Last bit: close the frame on this same edge so CS low spans exactly FRAME_BITS periods.
                    if (bit_cnt_q == BW'(FRAME_BITS - 1)) begin
                        state_d    = DONE;
                        cs_n_d     = 1'b1;
                        sync_n_d   = 1'b1;
                        sdata_d    = 1'b0;
                        sample_d   = rx_shift;
                        valid_d    = 1'b1;
                        dac_word_d = FRAME_BITS'({DAC_CTRL_NORMAL, dac_data});
                        gap_cnt_d  = '0;
`ifdef SEQ_RAMP_EN
                        ramp_d     = dac_data;
`endif
                    end
                end
            end
            DONE, GAP: begin
                state_d = GAP;
                // Hand over to START one rise early so its fall is the last gap fall;
                // parking in IDLE waits for that fall so sclk is already low.
                if (gap_cnt_q == GW'(GAP_CYCLES - 1)) begin
                    if (rise_tick && enable) state_d = START;
                    else if (fall_tick)      state_d = IDLE;
                end else if (fall_tick) begin
                    gap_cnt_d = gap_cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            bit_cnt_q  <= '0;
            gap_cnt_q  <= '0;
            rx_q       <= '0;
            tx_q       <= '0;
            dac_word_q <= '0;
            cs_n_q     <= 1'b1;
            sync_n_q   <= 1'b1;
            sdata_q    <= 1'b0;
            sample_q   <= '0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
            rx_q       <= rx_d;
            tx_q       <= tx_d;
            dac_word_q <= dac_word_d;
            cs_n_q     <= cs_n_d;
            sync_n_q   <= sync_n_d;
            sdata_q    <= sdata_d;
            sample_q   <= sample_d;
            valid_q    <= valid_d;
        end
    end

`ifdef SEQ_RAMP_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) ramp_q <= '0;
        else       ramp_q <= ramp_d;
    end
`endif

    assign adc_cs_n     = cs_n_q;
    assign dac_sync_n   = sync_n_q;
    assign dac_sdata    = sdata_q;
    assign sample       = sample_q;
    assign sample_valid = valid_q;
    assign busy         = (state_q != IDLE);
endmodule

// File: doc/spi_passthru_sequencer.md
Name: spi_passthru_sequencer

Overview:
Frame-level controller for the ADC-to-DAC pass-through path.
- Owns the serial clock and both chip selects.
- Runs back-to-back 16-bit SPI frames: one word in from the ADC, one word out to the DAC on the same SCLK.
- Each captured 12-bit sample goes to the DAC on the following frame.
- Sits between the board clock and the Pmod ADC/DAC pins, and replaces the free-running serial clock divider as the single source of SCLK.

Parameters:
CLK_DIV, 2, system clocks per SCLK half-period (SCLK = clock/(2*CLK_DIV)); legal range >= 1.
FRAME_BITS, 16, SCLK cycles per frame.
DATA_BITS, 12, sample width; the sample is the low DATA_BITS of the received frame.
GAP_CYCLES, 2, SCLK periods with both selects high between frames (>= 1).

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high reset
enable  in  1  run frames while high
adc_sdata  in  1  ADC serial data, MSB first
sclk  out  1  shared serial clock to ADC and DAC
adc_cs_n  out  1  ADC chip select, active low
dac_sync_n  out  1  DAC sync, active low
dac_sdata  out  1  DAC serial data, MSB first
sample  out  DATA_BITS  last captured sample
sample_valid  out  1  one-clock pulse when sample updates
busy  out  1  high from START through end of GAP

Behaviour:
- Reset (async, active-high): state IDLE; sclk=0; adc_cs_n=1; dac_sync_n=1; dac_sdata=0; sample=0; sample_valid=0; busy=0; DAC holding word=0; divider count=0.
- Divider:
  - count runs 0..CLK_DIV-1, but only outside IDLE; in IDLE it is held at 0 and sclk is held low.
  - At count==CLK_DIV-1, sclk toggles.
  - rise_tick marks a 0->1 transition; fall_tick marks a 1->0 transition. Each is a one-clock internal strobe coincident with the sclk edge it marks.
- FSM:
  - IDLE: when enable=1, go to START next clock; busy=1.
  - START: on the first fall_tick, drive adc_cs_n=0 and dac_sync_n=0, drive dac_sdata = DAC word bit 15, bit counter=0, go to SHIFT.
  - SHIFT:
    - On each fall_tick: sample adc_sdata into the MSB-first shift register and increment the bit counter.
    - On each rise_tick, while the bit counter < FRAME_BITS: present the next DAC bit on dac_sdata.
    - After the FRAME_BITS-th sample (fall_tick with counter reaching FRAME_BITS), go to DONE.
  - DONE (one clock): adc_cs_n=1, dac_sync_n=1, dac_sdata=0; sample <= rx[DATA_BITS-1:0]; sample_valid=1; DAC holding word <= {4'b0000, rx[11:0]}; go to GAP.
  - GAP: count GAP_CYCLES fall_ticks. Then go to START if enable=1, else IDLE (busy=0, sclk parked low).
- DAC word format: bits 15:12 = 0000 (normal mode), bits 11:0 = data. Latency: the DAC emits frame N's sample during frame N+1.
- Frame length with CLK_DIV=2: 64 clocks of CS low; gap = 4*GAP_CYCLES clocks.
- enable dropping mid-frame: the current frame completes, sample_valid still pulses, then IDLE after GAP. A frame is never truncated.
- enable=1 continuously: frames repeat with exactly GAP_CYCLES SCLK periods of CS high between them.
- Reset asserted mid-frame: all outputs return to reset values immediately (asynchronously); the partial frame is discarded and sample_valid is not pulsed.
- The ADC's four leading zero bits are not checked; only the low DATA_BITS are kept.

Optional Feature:
SEQ_RAMP_EN
- Defined: the DAC data field is an internal DATA_BITS counter. It resets to 0, increments by 1 (wrapping 4095->0) at each DONE, and is used in place of the captured sample. ADC capture, sample and sample_valid are unchanged.
- Undefined: the counter logic is absent and the DAC is pure pass-through.

Decomposition:
- Package spi_seq_pkg: state enum (IDLE, START, SHIFT, DONE, GAP), FRAME_BITS_C=16, DATA_BITS_C=12, DAC_CTRL_NORMAL=4'b0000.
- One sub-module: sclk_tick_gen. Inputs: clock, reset, run. Outputs: sclk, rise_tick, fall_tick. It contains the divider only.

Test Plan:
1. Reset, then enable=1 with CLK_DIV=2 -> adc_cs_n falls on the first sclk fall; exactly 16 sclk rising edges while it is low; adc_cs_n low for 64 clocks.
2. ADC model drives 0x0ABC -> sample=0xABC with a one-clock sample_valid at DONE; the next frame's dac_sdata bitstream is 0x0ABC MSB first, stable across each sclk falling edge.
3. Continuous enable with ADC words 0x0123, 0x0FFF, 0x0000 -> sample_valid pulses spaced 64+8 clocks apart; the DAC emits 0x0000 (reset word), then 0x0123, then 0x0FFF.
4. enable dropped at bit 5 of a frame -> the frame finishes all 16 bits, sample_valid pulses, the 8-clock gap completes, then IDLE with sclk=0 and busy=0.
5. reset asserted at bit 9 -> adc_cs_n=1, dac_sync_n=1, sclk=0, sample=0 within the same clock, with no sample_valid. After release with enable=1, a full 16-bit frame runs.
6. With SEQ_RAMP_EN defined -> DAC words 0x0000, 0x0001, 0x0002... across consecutive frames; 4096 frames later the ramp wraps to 0x0000.
